sys_array_ctrl: RTL

//   Sequencer for the 16-PE weight-stationary systolic chain of the conv layer.

---
 rtl/sys_array_ctrl_if.sv | 12 +
 rtl/sys_array_ctrl.sv | 120 ++++++++++++
 2 files changed

// File: rtl/sys_array_ctrl_if.sv
// Window stream between the im2col producer and the systolic-chain sequencer.
// The producer drives valid/data; the sequencer answers with ready.
interface sys_array_ctrl_if #(
   parameter int WIN_W = 216
);
   logic             win_valid;
   logic             win_ready;
   logic [WIN_W-1:0] win_data;

   modport master (output win_valid, output win_data, input win_ready);
   modport slave  (input win_valid, input win_data, output win_ready);
endinterface

// File: rtl/sys_array_ctrl.sv
// Sequencer for a weight-stationary systolic chain of NUM_OF_FILTERS PEs.
// Issues one im2col window per cycle onto a0 and follows each window through
// the PE skew with a {valid, idx} tag pipeline, so res_valid[k] marks the
// cycle PE k's out_c holds that window's result. done pulses once the last
// window has left the final PE.
module sys_array_ctrl #(
   parameter int NUM_OF_FILTERS = 16,
   parameter int WIN_W          = 216,
   parameter int PE_LAT         = 1,
   parameter int CNT_W          = 16
) (
   input  logic                      clk_i,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic                      abort,
   input  logic [CNT_W-1:0]          num_windows,
   sys_array_ctrl_if.slave           win,
   output logic [WIN_W-1:0]          a0,
   output logic [NUM_OF_FILTERS-1:0] res_valid,
   output logic [CNT_W-1:0]          res_win_idx,
   output logic                      busy,
   output logic                      done,
   output logic [CNT_W-1:0]          issued_cnt
);

   // Stage 0 is the cycle a window sits on a0; stage k+PE_LAT feeds res_valid[k].
   localparam int DEPTH     = NUM_OF_FILTERS + PE_LAT;
   // Cycles spent in DRAIN so done lands one cycle after the last PE result.
   localparam int DRAIN_CYC = NUM_OF_FILTERS - 1 + PE_LAT;
   localparam int DC_W      = $clog2(DRAIN_CYC + 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   typedef struct packed {
      logic             valid;
      logic [CNT_W-1:0] idx;
   } tag_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] n_q;
   logic [DC_W-1:0]  drain_cnt;
   tag_t             pipe [DEPTH];
   logic             accept;
   logic             start_ok;

   assign win.win_ready = (state_q == S_RUN) && (issued_cnt < n_q);
   // abort wins over a same-cycle transfer or start.
   assign accept        = win.win_valid && win.win_ready && !abort;
   assign start_ok      = (state_q == S_IDLE) && start && !abort;

   assign busy        = (state_q == S_RUN) || (state_q == S_DRAIN);
   assign done        = (state_q == S_DONE);
   assign res_win_idx = pipe[PE_LAT].idx;

   // State register.
   // NOTE: sequential state is written with non-blocking assignments only, so
   // every flop samples values from before the clock edge.
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next-state decode; abort overrides every transition.
   // NOTE: state_d gets a default before the case so no path infers a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start) state_d = (num_windows == '0) ? S_DONE : S_RUN;
         S_RUN:   if (issued_cnt == n_q) state_d = S_DRAIN;
         S_DRAIN: if (drain_cnt == DC_W'(DRAIN_CYC - 1)) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (abort) state_d = S_IDLE;
   end

   // Job length latch and window counter; the count holds after the job ends.
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         n_q        <= '0;
         issued_cnt <= '0;
      end else if (start_ok) begin
         n_q        <= num_windows;
         issued_cnt <= '0;
      end else if (accept) begin
         issued_cnt <= issued_cnt + CNT_W'(1);
      end
   end

   // Counts cycles spent in DRAIN; parked at zero elsewhere.
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n)                  drain_cnt <= '0;
      else if (state_q != S_DRAIN) drain_cnt <= '0;
      else                         drain_cnt <= drain_cnt + DC_W'(1);
   end

   // a0 drive and tag shift register; bubbles and idle cycles shift in zeros.
   // NOTE: the tag pipeline is reset (unlike a data RAM) because res_valid is
   // read straight from it and must be zero out of reset.
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         a0 <= '0;
         for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
      end else if (abort) begin
         a0 <= '0;
         for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
      end else begin
         a0      <= accept ? win.win_data : '0;
         pipe[0] <= accept ? tag_t'{valid: 1'b1, idx: issued_cnt} : '0;
         for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
      end
   end

   // Per-filter result strobes tapped from the tag pipeline.
   always_comb begin
      res_valid = '0;
      for (int k = 0; k < NUM_OF_FILTERS; k++) res_valid[k] = pipe[k+PE_LAT].valid;
   end

endmodule
